ahb_sram_ctrl: RTL

Parametrised AHB-Lite slave that maps a linear address region onto NUM_BANKS single-port synchronous SRAM banks, each with one-cycle read latency. It replaces the fixed 32-bit, single-bank SRAM wrapper in the memory subsystem. New capabilities: configurable data width, bank count and base address; per-byte write strobes driven to the SRAM; a proper two-cycle AHB ERROR response; and read-after-write collision stalling. The SRAM macros sit outside this block.

---
 rtl/ahb_sram_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl
// AHB-Lite slave that maps a linear, size-aligned address region onto
// NUM_BANKS single-port synchronous SRAM banks (one-cycle read latency).
// Reads access the SRAM in the address-phase cycle and return data with
// zero wait states. Writes access the SRAM in the data phase. A read that
// directly follows a write stalls for one cycle because the port is busy.
// Out-of-range, oversize or misaligned transfers get a two-cycle ERROR.
//
// Ports
//   hclk, hreset          clock, asynchronous active-high reset
//   hsel .. hready        AHB-Lite address/control inputs, hwdata (data phase)
//   hrdata, hreadyout,    AHB-Lite slave response
//   hresp
//   mem_cs/we/be/addr/    SRAM bank port (one-hot bank select, byte strobes)
//   mem_wdata, mem_rdata
//
// state   | meaning
// IDLE    | no data phase pending
// READ    | read data phase, hrdata from latched bank
// WRITE   | write data phase, SRAM written from latched address
// RSTALL  | read deferred behind a write, SRAM read issued, hreadyout low
// ERR1    | first ERROR cycle, hreadyout low
// ERR2    | second ERROR cycle, may accept a new transfer
module ahb_sram_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BANK_AW   = 12,
    parameter int unsigned NUM_BANKS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic                          hsel,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hsize,
    input  logic                          hwrite,
    input  logic [DATA_W-1:0]             hwdata,
    input  logic                          hready,
    output logic [DATA_W-1:0]             hrdata,
    output logic                          hreadyout,
    output logic                          hresp,
    output logic [NUM_BANKS-1:0]          mem_cs,
    output logic                          mem_we,
    output logic [DATA_W/8-1:0]           mem_be,
    output logic [BANK_AW-1:0]            mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BW        = DATA_W / 8;
    localparam int unsigned OFF       = $clog2(BW);
    localparam int unsigned BK        = $clog2(NUM_BANKS);
    localparam int unsigned BKW       = (BK == 0) ? 1 : BK;
    localparam int unsigned REGION_AW = OFF + BANK_AW + BK;
    localparam logic [2:0]  OFF3      = 3'(OFF);
    localparam logic [NUM_BANKS-1:0] CS_ONE = NUM_BANKS'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WRITE, ST_RSTALL, ST_ERR1, ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [BANK_AW-1:0] addr_q;
    logic [BKW-1:0]     bank_q;
    logic [BW-1:0]      be_q;
    logic               hreadyout_q, hresp_q;

    logic               valid_ap, ap_err, range_err, size_err, align_err;
    logic [7:0]         size_mask;
    logic [BKW-1:0]     ap_bank;
    logic [BANK_AW-1:0] ap_word;
    logic [BW-1:0]      be_base, ap_be;
    logic               take, rd_now;
    logic               unused_bits;

    // ---------------- address-phase decode ----------------
    assign valid_ap  = hsel & hready & htrans[1];
    assign range_err = haddr[31:REGION_AW] != BASE_ADDR[31:REGION_AW];
    assign size_err  = hsize > OFF3;
    assign size_mask = (8'd1 << hsize) - 8'd1;
    assign align_err = |(haddr[OFF-1:0] & size_mask[OFF-1:0]);
    assign ap_err    = range_err | size_err | align_err;
    assign ap_word   = haddr[OFF +: BANK_AW];
    assign ap_bank   = (BK == 0) ? '0 : haddr[OFF+BANK_AW +: BKW];

    // 2^hsize bytes of ones, shifted to the addressed byte lane
    assign be_base   = ~({BW{1'b1}} << (32'd1 << hsize));
    assign ap_be     = be_base << haddr[OFF-1:0];

    assign unused_bits = &{1'b0, htrans[0], size_mask[7:OFF]};

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_RSTALL: state_d = ST_READ;
            ST_ERR1:   state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (valid_ap) begin
                    if (ap_err) begin
                        state_d = ST_ERR1;
                    end else if (hwrite) begin
                        state_d = ST_WRITE;
                        take    = 1'b1;
                    end else if (state_q == ST_WRITE) begin
                        state_d = ST_RSTALL;
                        take    = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        take    = 1'b1;
                    end
                end
            end
        endcase
    end

    // Address-phase read goes straight to the SRAM; gated by hreset so a
    // selected bus during reset cannot strobe a bank.
    assign rd_now = (state_d == ST_READ) && (state_q != ST_RSTALL) && !hreset;

    // ---------------- state and registered outputs ----------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            bank_q      <= '0;
            be_q        <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= !((state_d == ST_ERR1) || (state_d == ST_RSTALL));
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            if (take) begin
                addr_q <= ap_word;
                bank_q <= ap_bank;
                be_q   <= hwrite ? ap_be : '0;
            end
        end
    end

    // ---------------- SRAM port ----------------
    always_comb begin
        mem_cs   = '0;
        mem_we   = 1'b0;
        mem_be   = '0;
        mem_addr = addr_q;
        if (state_q == ST_WRITE) begin
            mem_cs = CS_ONE << bank_q;
            mem_we = 1'b1;
            mem_be = be_q;
        end else if (state_q == ST_RSTALL) begin
            mem_cs = CS_ONE << bank_q;
        end else if (rd_now) begin
            mem_cs   = CS_ONE << ap_bank;
            mem_addr = ap_word;
        end
    end

    always_comb begin
        hrdata = '0;
        if (state_q == ST_READ) begin
            hrdata = mem_rdata[int'(bank_q)*DATA_W +: DATA_W];
        end
    end

    assign mem_wdata = hwdata;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule
